// File: rtl/cnn_buf_pkg.sv
// Shared types and defaults for the skewed input buffer feeding the PE array.
package cnn_buf_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        SKEW_ASC  = 2'd0,
        SKEW_DESC = 2'd1,
        SKEW_BYP  = 2'd2
    } skew_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } buf_state_e;

    // The reserved encoding 3 behaves exactly like bypass.
    function automatic skew_mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd0:    decode_mode = SKEW_ASC;
            2'd1:    decode_mode = SKEW_DESC;
            default: decode_mode = SKEW_BYP;
        endcase
    endfunction

endpackage

// File: rtl/skew_input_buffer_lane.sv
// One row lane: shift register of data/valid/last with a runtime output tap.
import cnn_buf_pkg::*;

module skew_lane #(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 31,
    localparam int TAP_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [TAP_W-1:0]  tap,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_last,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] data_q  [DEPTH+1];
    logic [DEPTH:0]    valid_q;
    logic [DEPTH:0]    last_q;

    // Shift one stage per enabled cycle. Stages beyond the tap are forced to
    // zero so a deeper tap chosen for the next tile never exposes stale beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            last_q  <= '0;
        end else if (en) begin
            data_q[0]  <= in_data;
            valid_q[0] <= in_valid;
            last_q[0]  <= in_last;
            for (int i = 1; i <= DEPTH; i++) begin
                if (i <= int'(tap)) begin
                    data_q[i]  <= data_q[i-1];
                    valid_q[i] <= valid_q[i-1];
                    last_q[i]  <= last_q[i-1];
                end else begin
                    data_q[i]  <= '0;
                    valid_q[i] <= 1'b0;
                    last_q[i]  <= 1'b0;
                end
            end
        end
    end

    assign out_valid = valid_q[tap];
    assign out_last  = valid_q[tap] & last_q[tap];
    assign out_data  = valid_q[tap] ? data_q[tap] : '0;

endmodule

// File: rtl/skew_input_buffer.sv
// Staggers one ROWS-wide activation beat per cycle into a diagonal wavefront
// for the systolic PE array, with handshake, stall and tile-end drain.
//
// state  | meaning
// IDLE   | no tile in flight; next accept latches the skew mode
// STREAM | tile in progress, beats accepted every cycle
// DRAIN  | last beat accepted, input blocked until out_last leaves
import cnn_buf_pkg::*;

module skew_input_buffer #(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ROWS   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_data  [ROWS],
    output logic [ROWS-1:0]   out_valid,
    output logic [DATA_W-1:0] out_data [ROWS],
    output logic              out_last,
    output logic              busy
);

    localparam int MAX_SKEW = ROWS - 1;
    localparam int TAP_W    = $clog2(MAX_SKEW + 1);

    buf_state_e state_q, state_d;
    skew_mode_e mode_q, mode_d;
    logic       accept;
    logic [TAP_W-1:0] lane_tap [ROWS];
    logic [ROWS-1:0]  lane_last;
    logic [ROWS-1:0]  last_mask;

    assign in_ready = !stall && (state_q != DRAIN);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE);

    // State and latched mode register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= SKEW_ASC;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic; mode is captured only on the first beat of a tile.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d  = decode_mode(mode);
                    state_d = in_last ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (accept && in_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (!stall && out_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The tile marker is only meaningful on the deepest lane of the mode.
    always_comb begin
        last_mask = '0;
        if (mode_q == SKEW_ASC) last_mask[ROWS-1] = 1'b1;
        else                    last_mask[0]      = 1'b1;
    end

    assign out_last = |(lane_last & last_mask);

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        assign lane_tap[r] = (mode_q == SKEW_ASC)  ? TAP_W'(r) :
                             (mode_q == SKEW_DESC) ? TAP_W'(ROWS - 1 - r) :
                                                     '0;

        skew_lane #(
            .DATA_W (DATA_W),
            .DEPTH  (MAX_SKEW)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en        (!stall),
            .tap       (lane_tap[r]),
            .in_valid  (accept),
            .in_last   (accept && in_last),
            .in_data   (accept ? in_data[r] : '0),
            .out_valid (out_valid[r]),
            .out_last  (lane_last[r]),
            .out_data  (out_data[r])
        );
    end

endmodule

// File: tb/tb_skew_input_buffer.sv
module tb_skew_input_buffer;

    localparam int ROWS = 4;
    localparam int DW   = 16;

    logic          clk;
    logic          rst;
    logic [1:0]    mode;
    logic          stall;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [DW-1:0] in_data  [ROWS];
    logic [ROWS-1:0] out_valid;
    logic [DW-1:0] out_data [ROWS];
    logic          out_last;
    logic          busy;

    skew_input_buffer #(.DATA_W(DW), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model: each accepted beat remembers the enabled-edge number it
    // entered on and the tile mode; lane r shows it 1+d(r) enabled edges later.
    typedef struct {
        int          edge_no;
        int          md;
        logic [63:0] d;
        bit          last;
    } beat_t;

    beat_t beats[$];
    int    n_edges = 0;
    bit    m_busy  = 0;
    bit    m_drain = 0;
    int    m_mode  = 0;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 0;
    int cyc_no   = 0;
    int last_seen = -1;

    function automatic int dly(input int md, input int r);
        if (md == 0) return r;
        if (md == 1) return ROWS - 1 - r;
        return 0;
    endfunction

    function automatic int max_lane(input int md);
        return (md == 0) ? ROWS - 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc_no, obs, exp);
        end
    endtask

    task automatic cyc(input bit rv, input bit lv, input logic [63:0] dv,
                       input logic [1:0] mv, input bit sv, input bit rstv);
        logic [3:0]  ev;
        logic [63:0] ed;
        logic [63:0] od;
        bit          el;
        bit          er;
        bit          acc;
        rst      = rstv;
        mode     = mv;
        stall    = sv;
        in_valid = rv;
        in_last  = lv;
        for (int r = 0; r < ROWS; r++) in_data[r] = dv[16*r +: 16];
        #1;
        ev = '0; ed = '0; el = 0;
        foreach (beats[i]) begin
            for (int r = 0; r < ROWS; r++) begin
                if (beats[i].edge_no + dly(beats[i].md, r) == n_edges - 1) begin
                    ev[r] = 1'b1;
                    ed[16*r +: 16] = beats[i].d[16*r +: 16];
                    if (r == max_lane(beats[i].md) && beats[i].last) el = 1;
                end
            end
        end
        er = !sv && !m_drain;
        od = '0;
        for (int r = 0; r < ROWS; r++) od[16*r +: 16] = out_data[r];
        if (chk_en) begin
            chk("out_valid", {60'd0, out_valid}, {60'd0, ev});
            chk("out_data", od, ed);
            chk("out_last", {63'd0, out_last}, {63'd0, el});
            chk("busy", {63'd0, busy}, {63'd0, m_busy});
            chk("in_ready", {63'd0, in_ready}, {63'd0, er});
            if (out_last === 1'b1 && last_seen < 0) last_seen = cyc_no;
        end
        acc = rv && er;
        @(posedge clk);
        if (rstv) begin
            beats.delete();
            m_drain = 0;
            m_busy  = 0;
        end else if (!sv) begin
            if (m_drain && el) begin
                m_drain = 0;
                m_busy  = 0;
            end
            if (acc) begin
                if (!m_busy) begin
                    m_mode = (mv == 2'd0) ? 0 : (mv == 2'd1) ? 1 : 2;
                    m_busy = 1;
                end
                beats.push_back('{edge_no: n_edges, md: m_mode, d: dv, last: lv});
                if (lv) m_drain = 1;
            end
            n_edges++;
            while (beats.size() > 0 && beats[0].edge_no + ROWS < n_edges) void'(beats.pop_front());
        end
        cyc_no++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [1:0] mv);
        for (int k = 0; k < n; k++) cyc(0, 0, 64'd0, mv, 0, 0);
    endtask

    int start;

    initial begin
        rst = 1'b1; mode = 2'd0; stall = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        for (int r = 0; r < ROWS; r++) in_data[r] = '0;
        @(negedge clk);
        cyc(0, 0, 64'd0, 2'd0, 0, 1);
        cyc(0, 0, 64'd0, 2'd0, 0, 1);
        chk_en = 1;
        idle(2, 2'd0);

        // Ascending single beat with last
        start = cyc_no; last_seen = -1;
        cyc(1, 1, 64'h0004_0003_0002_0001, 2'd0, 0, 0);
        idle(6, 2'd0);
        chk("asc_last_latency", 64'(last_seen - start), 64'd4);

        // Descending single beat
        start = cyc_no; last_seen = -1;
        cyc(1, 1, 64'h0004_0003_0002_0001, 2'd1, 0, 0);
        idle(6, 2'd1);
        chk("desc_last_latency", 64'(last_seen - start), 64'd4);

        // Bypass 3-beat tile, next tile offered immediately
        start = cyc_no; last_seen = -1;
        cyc(1, 0, 64'h000d_000c_000b_000a, 2'd2, 0, 0);
        cyc(1, 0, 64'h0017_0016_0015_0014, 2'd2, 0, 0);
        cyc(1, 1, 64'h0021_0020_001f_001e, 2'd2, 0, 0);
        cyc(1, 1, 64'h0044_0033_0022_0011, 2'd2, 0, 0);
        chk("byp_last_cycle", 64'(last_seen - start), 64'd3);
        cyc(1, 1, 64'h0044_0033_0022_0011, 2'd2, 0, 0);
        idle(3, 2'd2);

        // Ascending with stall in c2..c3
        start = cyc_no; last_seen = -1;
        cyc(1, 1, 64'h00a4_00a3_00a2_00a1, 2'd0, 0, 0);
        cyc(0, 0, 64'd0, 2'd0, 0, 0);
        cyc(0, 0, 64'd0, 2'd0, 1, 0);
        cyc(0, 0, 64'd0, 2'd0, 1, 0);
        idle(5, 2'd0);
        chk("stall_last_latency", 64'(last_seen - start), 64'd6);

        // Mode flips to descending mid-tile
        start = cyc_no; last_seen = -1;
        cyc(1, 0, 64'h0b04_0b03_0b02_0b01, 2'd0, 0, 0);
        cyc(1, 0, 64'h0c04_0c03_0c02_0c01, 2'd1, 0, 0);
        cyc(1, 1, 64'h0d04_0d03_0d02_0d01, 2'd1, 0, 0);
        idle(7, 2'd1);
        chk("flip_last_latency", 64'(last_seen - start), 64'd6);

        // Reset during DRAIN discards the tile
        last_seen = -1;
        cyc(1, 1, 64'h0e04_0e03_0e02_0e01, 2'd0, 0, 0);
        idle(2, 2'd0);
        cyc(0, 0, 64'd0, 2'd0, 0, 1);
        idle(6, 2'd0);
        chk("rst_drain_no_last", 64'(last_seen), 64'hffff_ffff_ffff_ffff);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom % 4) != 0, ($urandom % 4) == 0,
                {$urandom, $urandom}, 2'($urandom % 4),
                ($urandom % 6) == 0, ($urandom % 97) == 0);
        end
        idle(8, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
